// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts one ALU command at a time over a valid/ready
// handshake and runs it as READ -> EXEC -> WB against a small register file.
// The host can write and read the register file at any time through a side port.
//
// Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
// are both high; cmd_ready is high only in IDLE, and the command fields are
// sampled only on that edge.
//
// Optional build macro ALU_FLAG_EN adds res_zero and res_carry, registered
// together with res_data when the command executes.
module alu_cmd_sequencer #(
  parameter int         REG_ADDR_W = 2,
  parameter logic [3:0] REG_INIT   = 4'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [REG_ADDR_W-1:0] cmd_dst,
  input  logic [REG_ADDR_W-1:0] cmd_src1,
  input  logic [REG_ADDR_W-1:0] cmd_src2,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [3:0]            wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic [3:0]            rd_data,
  output logic                  res_valid,
  output logic [3:0]            res_data,
  output logic                  busy,
  output logic [1:0]            dbg_state
`ifdef ALU_FLAG_EN
  ,
  output logic                  res_zero,
  output logic                  res_carry
`endif
);

  localparam int NREGS = 1 << REG_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [2:0]            op_q,   op_d;
  logic [REG_ADDR_W-1:0] dst_q,  dst_d;
  logic [REG_ADDR_W-1:0] src1_q, src1_d;
  logic [REG_ADDR_W-1:0] src2_q, src2_d;
  logic [3:0]            opa_q,  opa_d;
  logic [3:0]            opb_q,  opb_d;
  logic [3:0]            res_data_q, res_data_d;
  logic [3:0]            regs_q [NREGS];
  logic [3:0]            regs_d [NREGS];

  logic [3:0]            src1_val;
  logic [3:0]            src2_val;
  logic [3:0]            alu_res;

`ifdef ALU_FLAG_EN
  logic res_zero_q,  res_zero_d;
  logic res_carry_q, res_carry_d;
  logic alu_carry;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed four-step walk, leaving IDLE only on a handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic decoded from the current state
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    res_valid = (state_q == ST_WB);
    dbg_state = state_q;
  end

  // Operand fetch with forwarding, so a host write landing on the same edge
  // as the operand latch is the value that gets used
  always_comb begin
    src1_val = regs_q[src1_q];
    src2_val = regs_q[src2_q];
    if (wr_en && (wr_addr == src1_q)) src1_val = wr_data;
    if (wr_en && (wr_addr == src2_q)) src2_val = wr_data;
  end

  // ALU function on the latched operands (rs = opa, rt = opb), mod 16
  always_comb begin
    alu_res = 4'h0;
    case (op_q)
      3'd0: alu_res = opa_q - opb_q;
      3'd1: alu_res = opa_q + opb_q;
      3'd2: alu_res = opa_q | opb_q;
      3'd3: alu_res = opa_q & opb_q;
      3'd4: alu_res = {opb_q[3], opb_q[3:1]};
      3'd5: alu_res = {opa_q[2:0], opa_q[3]};
      3'd6: alu_res = {3'b101, (opa_q < opb_q)};
      3'd7: alu_res = {3'b111, (opa_q == opb_q)};
      default: alu_res = 4'h0;
    endcase
  end

`ifdef ALU_FLAG_EN
  // Carry-out of the add, borrow of the subtract, zero for everything else
  always_comb begin
    alu_carry = 1'b0;
    if (op_q == 3'd1) alu_carry = (({1'b0, opa_q} + {1'b0, opb_q}) > 5'd15);
    if (op_q == 3'd0) alu_carry = (opa_q < opb_q);
  end
`endif

  // Datapath next-state: command latch, operand latch, result latch, regfile
  always_comb begin
    op_d       = op_q;
    dst_d      = dst_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    res_data_d = res_data_q;
    regs_d     = regs_q;
`ifdef ALU_FLAG_EN
    res_zero_d  = res_zero_q;
    res_carry_d = res_carry_q;
`endif

    if ((state_q == ST_IDLE) && cmd_valid) begin
      op_d   = cmd_op;
      dst_d  = cmd_dst;
      src1_d = cmd_src1;
      src2_d = cmd_src2;
    end

    if (state_q == ST_READ) begin
      opa_d = src1_val;
      opb_d = src2_val;
    end

    if (state_q == ST_EXEC) begin
      res_data_d = alu_res;
`ifdef ALU_FLAG_EN
      res_zero_d  = (alu_res == 4'h0);
      res_carry_d = alu_carry;
`endif
    end

    // Host write first, write-back second: write-back wins on the same index
    if (wr_en) regs_d[wr_addr] = wr_data;
    if (state_q == ST_WB) regs_d[dst_q] = res_data_q;
  end

  // Datapath registers; reset aborts any command in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= 3'd0;
      dst_q      <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      opa_q      <= 4'h0;
      opb_q      <= 4'h0;
      res_data_q <= 4'h0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= REG_INIT;
`ifdef ALU_FLAG_EN
      res_zero_q  <= 1'b0;
      res_carry_q <= 1'b0;
`endif
    end else begin
      op_q       <= op_d;
      dst_q      <= dst_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      res_data_q <= res_data_d;
      regs_q     <= regs_d;
`ifdef ALU_FLAG_EN
      res_zero_q  <= res_zero_d;
      res_carry_q <= res_carry_d;
`endif
    end
  end

  // Host read port and result outputs
  always_comb begin
    rd_data  = regs_q[rd_addr];
    res_data = res_data_q;
`ifdef ALU_FLAG_EN
    res_zero  = res_zero_q;
    res_carry = res_carry_q;
`endif
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed commands with literal expectations plus
// a latency-based reference model compared on every falling edge.
module tb_alu_cmd_sequencer;

  localparam int AW = 2;
  localparam int NR = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n     = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op    = 3'd0;
  logic [AW-1:0] cmd_dst   = '0;
  logic [AW-1:0] cmd_src1  = '0;
  logic [AW-1:0] cmd_src2  = '0;
  logic          wr_en     = 1'b0;
  logic [AW-1:0] wr_addr   = '0;
  logic [3:0]    wr_data   = 4'h0;
  logic [AW-1:0] rd_addr   = '0;
  logic [3:0]    rd_data;
  logic          res_valid;
  logic [3:0]    res_data;
  logic          busy;
  logic [1:0]    dbg_state;
`ifdef ALU_FLAG_EN
  logic          res_zero;
  logic          res_carry;
`endif

  alu_cmd_sequencer #(.REG_ADDR_W(AW), .REG_INIT(4'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_src1  (cmd_src1),
    .cmd_src2  (cmd_src2),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .res_valid (res_valid),
    .res_data  (res_data),
    .busy      (busy),
    .dbg_state (dbg_state)
`ifdef ALU_FLAG_EN
    ,
    .res_zero  (res_zero),
    .res_carry (res_carry)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // ALU rules written as plain integer arithmetic
  function automatic logic [3:0] alu_model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      3'd0: r = (ia - ib + 16) % 16;
      3'd1: r = (ia + ib) % 16;
      3'd2: r = int'(a | b);
      3'd3: r = int'(a & b);
      3'd4: r = ib / 2 + ((ib >= 8) ? 8 : 0);
      3'd5: r = (ia * 2) % 16 + ia / 8;
      3'd6: r = 10 + ((ia < ib) ? 1 : 0);
      default: r = 14 + ((ia == ib) ? 1 : 0);
    endcase
    return r[3:0];
  endfunction

  function automatic logic carry_model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    if (op == 3'd1) return (int'(a) + int'(b)) > 15;
    if (op == 3'd0) return int'(a) < int'(b);
    return 1'b0;
  endfunction

  // Model keeps a pending command and the number of edges since it was taken
  logic [3:0]    m_regs [NR];
  logic [3:0]    m_next [NR];
  bit            m_pend = 1'b0;
  int            m_age  = 0;
  logic [2:0]    m_op   = 3'd0;
  logic [AW-1:0] m_dst  = '0;
  logic [AW-1:0] m_s1   = '0;
  logic [AW-1:0] m_s2   = '0;
  logic [3:0]    m_a    = 4'h0;
  logic [3:0]    m_b    = 4'h0;
  logic [3:0]    m_res  = 4'h0;
  logic          m_zero = 1'b0;
  logic          m_carry = 1'b0;

  initial for (int i = 0; i < NR; i++) m_regs[i] = 4'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) m_regs[i] = 4'h0;
      m_pend = 1'b0; m_age = 0; m_res = 4'h0; m_zero = 1'b0; m_carry = 1'b0;
    end else begin
      m_next = m_regs;
      if (wr_en) m_next[wr_addr] = wr_data;
      if (m_pend) begin
        m_age++;
        if (m_age == 1) begin
          m_a = m_next[m_s1];
          m_b = m_next[m_s2];
        end else if (m_age == 2) begin
          m_res   = alu_model(m_op, m_a, m_b);
          m_zero  = (m_res == 4'h0);
          m_carry = carry_model(m_op, m_a, m_b);
        end else if (m_age == 3) begin
          m_next[m_dst] = m_res;
          m_pend = 1'b0;
        end
      end else if (cmd_valid) begin
        m_pend = 1'b1; m_age = 0;
        m_op = cmd_op; m_dst = cmd_dst; m_s1 = cmd_src1; m_s2 = cmd_src2;
      end
      m_regs = m_next;
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_cmd_ready", {7'd0, cmd_ready}, {7'd0, !m_pend});
      check("m_busy",      {7'd0, busy},      {7'd0, m_pend});
      check("m_res_valid", {7'd0, res_valid}, {7'd0, (m_pend && m_age == 2)});
      check("m_res_data",  {4'd0, res_data},  {4'd0, m_res});
      check("m_rd_data",   {4'd0, rd_data},   {4'd0, m_regs[rd_addr]});
`ifdef ALU_FLAG_EN
      check("m_res_zero",  {7'd0, res_zero},  {7'd0, m_zero});
      check("m_res_carry", {7'd0, res_carry}, {7'd0, m_carry});
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] a, input logic [3:0] exp);
    rd_addr = a;
    #1;
    check(name, {4'd0, rd_data}, {4'd0, exp});
  endtask

  // Issue one command, check the WB cycle and the register afterwards.
  // Optionally drive a host write during the WB cycle.
  task automatic run_cmd(input string name, input logic [2:0] op, input logic [AW-1:0] dst,
                         input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic [3:0] exp,
                         input logic exp_c, input logic exp_z,
                         input bit wb_wr, input logic [AW-1:0] wb_a, input logic [3:0] wb_d);
    bit got;
    got = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src1 = s1; cmd_src2 = s2;
    for (int n = 0; n < 20 && !got; n++) begin
      if (cmd_ready) got = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    check({name, "_accept"}, {7'd0, got}, 8'd1);
    tick();
    tick();
    check({name, "_valid"}, {7'd0, res_valid}, 8'd1);
    check({name, "_data"},  {4'd0, res_data},  {4'd0, exp});
`ifdef ALU_FLAG_EN
    check({name, "_carry"}, {7'd0, res_carry}, {7'd0, exp_c});
    check({name, "_zero"},  {7'd0, res_zero},  {7'd0, exp_z});
`else
    if (exp_c === 1'bx || exp_z === 1'bx) $display("note: unknown flag expectation in %s", name);
`endif
    if (wb_wr) begin
      wr_en = 1'b1; wr_addr = wb_a; wr_data = wb_d;
    end
    tick();
    wr_en = 1'b0;
    check({name, "_valid_drop"}, {7'd0, res_valid}, 8'd0);
    read_check({name, "_reg"}, dst, exp);
  endtask

  // ---------------- directed sequence ----------------
  int acc_cyc [3];
  int n_acc;
  int pulses;

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    check("rst_busy",      {7'd0, busy},      8'd0);
    check("rst_res_valid", {7'd0, res_valid}, 8'd0);
    check("rst_res_data",  {4'd0, res_data},  8'd0);
    for (int i = 0; i < NR; i++) read_check("rst_reg", i[AW-1:0], 4'h0);
    rst_n = 1'b1;
    tick();

    host_write(0, 4'd5); host_write(1, 4'd3);
    run_cmd("sub", 3'd0, 2, 0, 1, 4'h2, 1'b0, 1'b0, 1'b0, 0, 4'h0);

    host_write(0, 4'd9); host_write(1, 4'd8);
    run_cmd("add_wrap", 3'd1, 3, 0, 1, 4'h1, 1'b1, 1'b0, 1'b0, 0, 4'h0);

    host_write(1, 4'b1010);
    run_cmd("asr", 3'd4, 2, 0, 1, 4'b1101, 1'b0, 1'b0, 1'b0, 0, 4'h0);
    run_cmd("rol", 3'd5, 2, 0, 1, 4'b0011, 1'b0, 1'b0, 1'b0, 0, 4'h0);

    host_write(0, 4'd3); host_write(1, 4'd5);
    run_cmd("ltu", 3'd6, 2, 0, 1, 4'b1011, 1'b0, 1'b0, 1'b0, 0, 4'h0);
    run_cmd("sub_borrow", 3'd0, 3, 0, 1, 4'hE, 1'b1, 1'b0, 1'b0, 0, 4'h0);

    host_write(0, 4'd6); host_write(1, 4'd6);
    run_cmd("eq", 3'd7, 3, 0, 1, 4'b1111, 1'b0, 1'b0, 1'b0, 0, 4'h0);
    run_cmd("self_add", 3'd1, 0, 0, 0, 4'hC, 1'b0, 1'b0, 1'b0, 0, 4'h0);
    run_cmd("or", 3'd2, 2, 0, 1, 4'hE, 1'b0, 1'b0, 1'b0, 0, 4'h0);
    run_cmd("and", 3'd3, 2, 0, 1, 4'h4, 1'b0, 1'b0, 1'b0, 0, 4'h0);
    run_cmd("sub_zero", 3'd0, 3, 1, 1, 4'h0, 1'b0, 1'b1, 1'b0, 0, 4'h0);

    // cmd_valid held high: r0 += r1 three times (C -> 2 -> 8 -> E)
    n_acc = 0; pulses = 0;
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_dst = 0; cmd_src1 = 0; cmd_src2 = 1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cmd_valid && cmd_ready && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (res_valid) pulses++;
      tick();
      if (n_acc == 3) cmd_valid = 1'b0;
    end
    check("b2b_accepts", n_acc[7:0], 8'd3);
    check("b2b_gap1", 8'(acc_cyc[1] - acc_cyc[0]), 8'd4);
    check("b2b_gap2", 8'(acc_cyc[2] - acc_cyc[1]), 8'd4);
    check("b2b_pulses", pulses[7:0], 8'd3);
    read_check("b2b_r0", 0, 4'hE);

    // Write-back collides with a host write to the same register
    host_write(0, 4'd2); host_write(1, 4'd3);
    run_cmd("wb_wins", 3'd1, 2, 0, 1, 4'h5, 1'b0, 1'b0, 1'b1, 2, 4'hF);
    run_cmd("wb_other", 3'd1, 2, 0, 1, 4'h5, 1'b0, 1'b0, 1'b1, 3, 4'hA);
    read_check("wb_other_r3", 3, 4'hA);

    // Reset during EXEC aborts the command
    host_write(2, 4'h7);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_dst = 2; cmd_src1 = 0; cmd_src2 = 1;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_res_valid", {7'd0, res_valid}, 8'd0);
    check("abort_busy",      {7'd0, busy},      8'd0);
    check("abort_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    check("abort_res_data",  {4'd0, res_data},  8'd0);
    for (int i = 0; i < NR; i++) read_check("abort_reg", i[AW-1:0], 4'h0);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (res_valid) pulses++;
      tick();
    end
    check("abort_no_pulse", pulses[7:0], 8'd0);
    read_check("abort_r2", 2, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
